// File: rtl/weight_sram_pkg.sv
// Shared definitions for the weight SRAM controller: geometry, FSM state codes,
// the burst command record and the read-data sign extension helper.
package weight_sram_pkg;

    localparam int WSRAM_DEPTH = 81920;   // 5 banks x 16384 words
    localparam int BANK_WORDS  = 16384;
    localparam int ADDR_W      = 17;
    localparam int DATA_W      = 18;
    localparam int RDATA_W     = 32;
    localparam int CMD_ID_W    = 2;       // holds ids of up to 4 requesters
    localparam int CMD_LEN_W   = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RD_BURST = 2'd1;
    localparam logic [1:0] ST_WR_BURST = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        RD_BURST = ST_RD_BURST,
        WR_BURST = ST_WR_BURST
    } state_e;

    typedef struct packed {
        logic [CMD_ID_W-1:0]  id;
        logic                 write;
        logic [ADDR_W-1:0]    addr;
        logic [CMD_LEN_W-1:0] len;
    } cmd_t;

    // 18-bit RAM words are signed weights; widen to the 32-bit return bus.
    function automatic logic [RDATA_W-1:0] sext_word(input logic [DATA_W-1:0] w);
        return {{(RDATA_W-DATA_W){w[DATA_W-1]}}, w};
    endfunction

endpackage

// File: rtl/weight_sram_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting at the pointer
// and returns the first hit as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N = 3,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_id,
    output logic            o_any
);

    // Walk the requesters once, wrapping at N, and keep the first one found.
    always_comb begin
        logic [ID_W-1:0] w_idx;
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_idx   = i_ptr;
        for (int k = 0; k < N; k++) begin
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = w_idx;
            end
            w_idx = (w_idx == ID_W'(N-1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/weight_sram_ctrl.sv
// Burst sequencer in front of the single-port weight SRAM. Arbitrates between
// requesters in IDLE, then issues one read beat per cycle or one write beat per
// accepted wvalid. Read data returns one cycle after issue, tagged with the id.
module weight_sram_ctrl
    import weight_sram_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int LEN_W = 8,
    parameter int DEPTH = WSRAM_DEPTH,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [N_REQ-1:0]          i_req_write,
    input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [N_REQ*LEN_W-1:0]    i_req_len,
    output logic [N_REQ-1:0]          o_req_err,
    input  logic                      i_wvalid,
    input  logic [DATA_W-1:0]         i_wdata,
    output logic                      o_wready,
    output logic                      o_rvalid,
    output logic [ID_W-1:0]           o_rid,
    output logic [RDATA_W-1:0]        o_rdata,
    output logic                      o_rlast,
    output logic                      o_busy,
    output logic                      o_mem_cs,
    output logic                      o_mem_oe,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic                      o_mem_w_req,
    output logic [DATA_W-1:0]         o_mem_w_data,
    input  logic [DATA_W-1:0]         i_mem_r_data
);

    state_e             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_beat;
    logic [ADDR_W-1:0]  r_cnt_addr;
    logic               r_rvalid;
    logic [ID_W-1:0]    r_rid;
    logic               r_rlast;

    logic [ADDR_W-1:0]  w_addr [N_REQ];
    logic [LEN_W-1:0]   w_len  [N_REQ];
    logic [N_REQ-1:0]   w_grant;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_any;
    cmd_t               w_win_cmd;
    logic               w_range_err;
    logic [ID_W-1:0]    w_ptr_next;
    logic               w_idle;
    logic               w_rd_beat;
    logic               w_wr_beat;
    logic               w_beat;
    logic               w_last_beat;

    // Split the flat per-requester command buses into indexable arrays.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_addr[gi] = i_req_addr[gi*ADDR_W +: ADDR_W];
            assign w_len[gi]  = i_req_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_id    (w_gnt_id),
        .o_any   (w_any)
    );

    assign w_win_cmd.id    = CMD_ID_W'(w_gnt_id);
    assign w_win_cmd.write = i_req_write[w_gnt_id];
    assign w_win_cmd.addr  = w_addr[w_gnt_id];
    assign w_win_cmd.len   = CMD_LEN_W'(w_len[w_gnt_id]);

    // Last beat address must stay inside the populated word range; no wrap.
    assign w_range_err = (32'(w_win_cmd.addr) + 32'(w_win_cmd.len)) >= 32'(DEPTH);
    assign w_ptr_next  = (w_gnt_id == ID_W'(N_REQ-1)) ? '0 : w_gnt_id + 1'b1;

    assign w_idle      = (r_state == IDLE);
    assign w_rd_beat   = (r_state == RD_BURST);
    assign w_wr_beat   = (r_state == WR_BURST) && i_wvalid;
    assign w_beat      = w_rd_beat || w_wr_beat;
    assign w_last_beat = (r_beat == r_len);

    // Command accept is combinational in IDLE; a range reject shares the grant cycle.
    assign o_req_ready = w_idle ? w_grant : '0;
    assign o_req_err   = (w_idle && w_range_err) ? w_grant : '0;

    assign o_mem_cs     = w_beat;
    assign o_mem_w_req  = ~w_wr_beat;
    assign o_mem_addr   = r_cnt_addr;
    assign o_mem_w_data = (r_state == WR_BURST) ? i_wdata : '0;
    assign o_wready     = w_wr_beat;
    assign o_mem_oe     = r_rvalid;

    assign o_rvalid = r_rvalid;
    assign o_rid    = r_rid;
    assign o_rlast  = r_rlast;
    assign o_rdata  = r_rvalid ? sext_word(i_mem_r_data) : '0;
    assign o_busy   = !w_idle || r_rvalid;

    // Burst FSM, round-robin pointer and beat/address counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_id       <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_cnt_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ptr <= w_ptr_next;
                        if (!w_range_err) begin
                            r_id       <= w_win_cmd.id[ID_W-1:0];
                            r_len      <= w_win_cmd.len[LEN_W-1:0];
                            r_beat     <= '0;
                            r_cnt_addr <= w_win_cmd.addr;
                            r_state    <= w_win_cmd.write ? WR_BURST : RD_BURST;
                        end
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (w_beat) begin
                        r_cnt_addr <= r_cnt_addr + 1'b1;
                        r_beat     <= r_beat + 1'b1;
                        if (w_last_beat) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // One-stage tag pipeline matching the RAM's single-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rlast  <= 1'b0;
        end else begin
            r_rvalid <= w_rd_beat;
            r_rid    <= r_id;
            r_rlast  <= w_rd_beat && w_last_beat;
        end
    end

endmodule

// File: tb/tb_weight_sram_ctrl.sv
// Bench for weight_sram_ctrl: behavioural SRAM, transaction-level reference
// model checked every cycle, directed scenarios with literal expectations,
// then randomized multi-requester traffic.
module tb_weight_sram_ctrl;
    import weight_sram_pkg::*;

    localparam int N     = 3;
    localparam int LW    = 8;
    localparam int AW    = 17;
    localparam int DEPTH = 81920;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_write = '0;
    logic [N*AW-1:0]  req_addr  = '0;
    logic [N*LW-1:0]  req_len   = '0;
    logic             wvalid = 1'b0;
    logic [17:0]      wdata  = '0;
    logic [N-1:0]     req_ready, req_err;
    logic             wready, rvalid, rlast, busy;
    logic [1:0]       rid;
    logic [31:0]      rdata;
    logic             mem_cs, mem_oe, mem_w_req;
    logic [16:0]      mem_addr;
    logic [17:0]      mem_w_data;
    logic [17:0]      mem_r_data = '0;

    always #5 clk = ~clk;

    weight_sram_ctrl #(.N_REQ(N), .LEN_W(LW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_len(req_len), .o_req_err(req_err),
        .i_wvalid(wvalid), .i_wdata(wdata), .o_wready(wready),
        .o_rvalid(rvalid), .o_rid(rid), .o_rdata(rdata), .o_rlast(rlast), .o_busy(busy),
        .o_mem_cs(mem_cs), .o_mem_oe(mem_oe), .o_mem_addr(mem_addr),
        .o_mem_w_req(mem_w_req), .o_mem_w_data(mem_w_data), .i_mem_r_data(mem_r_data)
    );

    // Power-up content of never-written words, shared by SRAM and model.
    function automatic logic [17:0] init_val(input int a);
        logic [31:0] t;
        t = a * 32'd40503 + 32'h1357;
        return t[17:0] ^ t[31:14];
    endfunction

    // Behavioural single-port SRAM, one-cycle registered read.
    logic [17:0] ram    [0:DEPTH-1];
    bit          ram_wr [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_cs && !mem_w_req) begin
            ram[mem_addr]    <= mem_w_data;
            ram_wr[mem_addr] <= 1'b1;
        end else if (mem_cs) begin
            mem_r_data <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
        end
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: arbitration and beat schedule from the rules, one step per cycle.
    logic [17:0] shadow [0:DEPTH-1];
    int  m_ptr = 0;
    bit  m_act = 1'b0;
    bit  m_wr  = 1'b0;
    int  m_id = 0, m_addr = 0, m_left = 0;
    bit  m_rv = 1'b0;
    int  m_rid = 0;
    bit  m_rlast = 1'b0;
    logic [31:0] m_rdata = '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
        forever begin
            int win, a, l, idx;
            bit rerr, beat, wbeat, n_rv, n_last;
            int n_id;
            logic [31:0] n_data;
            logic [N-1:0] e_ready, e_err;
            @(negedge clk);
            win = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (win < 0 && req_valid[idx]) win = idx;
            end
            e_ready = '0; e_err = '0; rerr = 1'b0; a = 0; l = 0;
            if (!m_act && win >= 0) begin
                a = int'(req_addr[win*AW +: AW]);
                l = int'(req_len[win*LW +: LW]);
                rerr = (a + l) >= DEPTH;
                e_ready[win] = 1'b1;
                e_err[win]   = rerr;
            end
            wbeat = m_act && m_wr && wvalid;
            beat  = m_act && (!m_wr || wvalid);
            if (chk_en) begin
                chk("req_ready", 32'(req_ready), 32'(e_ready));
                chk("req_err", 32'(req_err), 32'(e_err));
                chk("mem_cs", 32'(mem_cs), 32'(beat));
                chk("mem_w_req", 32'(mem_w_req), 32'(!wbeat));
                chk("wready", 32'(wready), 32'(wbeat));
                if (beat) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                if (wbeat) chk("mem_w_data", 32'(mem_w_data), 32'(wdata));
                chk("mem_oe", 32'(mem_oe), 32'(m_rv));
                chk("rvalid", 32'(rvalid), 32'(m_rv));
                if (m_rv) begin
                    chk("rid", 32'(rid), 32'(m_rid));
                    chk("rlast", 32'(rlast), 32'(m_rlast));
                    chk("rdata", rdata, m_rdata);
                end
                chk("busy", 32'(busy), 32'(m_act || m_rv));
            end
            n_rv = m_act && !m_wr;
            n_id = m_id;
            n_last = (m_left == 1);
            n_data = n_rv ? sext_word(shadow[m_addr]) : '0;
            if (beat) begin
                if (m_wr) shadow[m_addr] = wdata;
                m_addr++;
                m_left--;
                if (m_left == 0) m_act = 1'b0;
            end else if (e_ready != '0) begin
                m_ptr = (win + 1) % N;
                $display("txn id=%0d %s addr=%0d len=%0d %s", win,
                         req_write[win] ? "wr" : "rd", a, l, rerr ? "rejected" : "accepted");
                if (!rerr) begin
                    m_act = 1'b1; m_wr = req_write[win]; m_id = win;
                    m_addr = a; m_left = l + 1;
                end
            end
            m_rv = n_rv; m_rid = n_id; m_rlast = n_last; m_rdata = n_data;
            if (rst) begin
                m_act = 1'b0; m_ptr = 0; m_rv = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int id, input bit wr, input int addr, input int len);
        req_write[id] = wr;
        req_addr[id*AW +: AW] = AW'(addr);
        req_len[id*LW +: LW]  = LW'(len);
        req_valid[id] = 1'b1;
    endtask

    // Returns at posedge+1 of the first cycle after the grant.
    task automatic wait_grant(input int id, output bit err);
        bit got;
        got = 1'b0; err = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                err = req_err[id];
            end
            tick();
        end
        req_valid[id] = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL grant_timeout id=%0d: got no grant expected one", id);
        end
    endtask

    task automatic issue(input int id, input bit wr, input int addr, input int len, output bit err);
        set_cmd(id, wr, addr, len);
        wait_grant(id, err);
    endtask

    initial begin
        bit err, seen;
        int n;
        int g_id[3], g_cyc[3];
        logic [N-1:0] g;
        logic [5:0] m_cs, m_rv, m_last;
        logic [31:0] cap[4];
        logic [17:0] wd[5];
        bit pat[5];
        bit pend[N];

        // Reset
        repeat (1) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_w_req", 32'(mem_w_req), 32'd1);
        chk("rst_cs", 32'(mem_cs), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Contention from ptr=0: lens 1,2,0 -> grants at cycles 0,3,7
        set_cmd(0, 1'b0, 100, 1);
        set_cmd(1, 1'b0, 200, 2);
        set_cmd(2, 1'b0, 300, 0);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            g = req_ready;
            if (g != '0 && n < 3) begin
                g_id[n] = (g == 3'b001) ? 0 : (g == 3'b010) ? 1 : (g == 3'b100) ? 2 : 9;
                g_cyc[n] = c;
                n++;
            end
            tick();
            req_valid = req_valid & ~g;
        end
        chk("cont_count", n, 3);
        for (int i = 0; i < 3 && i < n; i++) begin
            chk("cont_id", g_id[i], i);
        end
        if (n == 3) begin
            chk("cont_cyc1", g_cyc[1] - g_cyc[0], 3);
            chk("cont_cyc2", g_cyc[2] - g_cyc[0], 7);
        end
        repeat (3) tick();

        // Single read addr 0 len 3
        issue(0, 1'b0, 0, 3, err);
        chk("single_err", 32'(err), 32'd0);
        m_cs = '0; m_rv = '0; m_last = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            m_cs[c-1] = mem_cs; m_rv[c-1] = rvalid; m_last[c-1] = rvalid && rlast;
            if (c <= 4) chk("single_addr", 32'(mem_addr), c - 1);
            if (rvalid) chk("single_rid", 32'(rid), 32'd0);
            tick();
        end
        chk("single_cs_cycles", 32'(m_cs), 32'b001111);
        chk("single_rv_cycles", 32'(m_rv), 32'b011110);
        chk("single_rlast", 32'(m_last), 32'b010000);

        // Range check at the top of the array
        issue(0, 1'b0, 81918, 2, err);
        chk("range_err_81918", 32'(err), 32'd1);
        @(negedge clk);
        chk("range_no_cs", 32'(mem_cs), 32'd0);
        tick();
        issue(1, 1'b0, 81917, 2, err);
        chk("range_ok_81917", 32'(err), 32'd0);
        repeat (5) tick();

        // Write with stall across bank 0 -> 1, then read back
        wd  = '{18'h0_1111, 18'h3_FFFF, 18'h2_2222, 18'h0_3333, 18'h1_4444};
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        issue(0, 1'b1, 16382, 3, err);
        for (int k = 0; k < 5; k++) begin
            wvalid = pat[k]; wdata = wd[k];
            tick();
        end
        wvalid = 1'b0;
        chk("bank_wr_16382", 32'(ram[16382]), 32'h0_1111);
        chk("bank_wr_16383", 32'(ram[16383]), 32'h2_2222);
        chk("bank_wr_16384", 32'(ram[16384]), 32'h0_3333);
        chk("bank_wr_16385", 32'(ram[16385]), 32'h1_4444);
        issue(2, 1'b0, 16382, 3, err);
        n = 0;
        for (int c = 0; c < 12 && n < 4; c++) begin
            @(negedge clk);
            if (rvalid) begin
                cap[n] = rdata;
                n++;
            end
        end
        tick();
        chk("readback_count", n, 4);
        if (n == 4) begin
            chk("readback0", cap[0], 32'h0000_1111);
            chk("readback1", cap[1], 32'hFFFE_2222);
            chk("readback2", cap[2], 32'h0000_3333);
            chk("readback3", cap[3], 32'h0001_4444);
        end

        // Sign extension of a stored negative word
        issue(1, 1'b1, 5, 0, err);
        wvalid = 1'b1; wdata = 18'h2_0001;
        tick();
        wvalid = 1'b0;
        issue(1, 1'b0, 5, 0, err);
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (rvalid) begin
                chk("sext_rdata", rdata, 32'hFFFE_0001);
                seen = 1'b1;
            end
        end
        tick();
        chk("sext_seen", 32'(seen), 32'd1);

        // Reset during beat 2 of a len=7 read
        issue(0, 1'b0, 1000, 7, err);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_cmd(0, 1'b0, 2000, 1);
        set_cmd(2, 1'b0, 3000, 1);
        @(negedge clk);
        chk("abort_cs", 32'(mem_cs), 32'd0);
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ptr_grant", 32'(req_ready), 32'b001);
        tick();
        req_valid[0] = 1'b0;
        wait_grant(2, err);
        repeat (4) tick();

        // Randomized traffic from all requesters
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            g = req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (pend[i] && g[i]) begin
                    req_valid[i] = 1'b0;
                    pend[i] = 1'b0;
                end
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    int a;
                    if ($urandom_range(0, 7) == 0) a = DEPTH - 8 + int'($urandom_range(0, 7));
                    else a = int'($urandom_range(0, DEPTH - 1));
                    set_cmd(i, 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 15)));
                    pend[i] = 1'b1;
                end
            end
            wvalid = ($urandom_range(0, 3) != 0);
            wdata  = 18'($urandom);
        end

        // Drain and confirm idle
        req_valid = '0;
        wvalid = 1'b1;
        repeat (40) tick();
        wvalid = 1'b0;
        @(negedge clk);
        chk("drain_idle", 32'(busy), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
